// File: rtl/lif_neuron_core.sv
// Single leaky integrate-and-fire neuron: leaks, integrates input current, fires at a
// programmable threshold and then holds in a refractory window.
module lif_neuron_core #(
  parameter int WIDTH         = 8,
  parameter int THRESHOLD     = 200,
  parameter int LEAK_SHIFT    = 4,
  parameter int REFRAC_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] current_in,
  input  logic             in_valid,
  input  logic             thr_load,
  input  logic [WIDTH-1:0] thr_in,
  output logic [WIDTH-1:0] membrane,
  output logic             spike,
  output logic             refractory,
  output logic [7:0]       spike_count,
  output logic             fsm_state
);

  localparam int CW = (REFRAC_CYCLES < 1) ? 1 : $clog2(REFRAC_CYCLES + 1);

  localparam logic [0:0] ST_INTEGRATE = 1'b0;
  localparam logic [0:0] ST_REFRACT   = 1'b1;

  logic [0:0]       state;
  logic [CW-1:0]    refrac_cnt;
  logic [WIDTH-1:0] threshold;
  logic [WIDTH-1:0] leaked;
  logic [WIDTH:0]   sum;
  logic             fire;
  logic [WIDTH-1:0] sum_sat;

  // The sum keeps one extra bit so the threshold compare sees the true value.
  always_comb begin
    leaked  = membrane - (membrane >> LEAK_SHIFT);
    sum     = {1'b0, leaked} + (in_valid ? {1'b0, current_in} : '0);
    fire    = (sum >= {1'b0, threshold});
    sum_sat = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_INTEGRATE;
      refrac_cnt  <= '0;
      threshold   <= WIDTH'(THRESHOLD);
      membrane    <= '0;
      spike       <= 1'b0;
      spike_count <= '0;
    end else if (ena) begin
      // A load takes effect after this edge; this cycle's compare uses the old value.
      if (thr_load) threshold <= thr_in;
      case (state)
        ST_INTEGRATE: begin
          if (fire) begin
            membrane    <= '0;
            spike       <= 1'b1;
            spike_count <= spike_count + 8'd1;
            if (REFRAC_CYCLES != 0) begin
              refrac_cnt <= CW'(REFRAC_CYCLES);
              state      <= ST_REFRACT;
            end
          end else begin
            membrane <= sum_sat;
            spike    <= 1'b0;
          end
        end
        default: begin
          membrane   <= '0;
          spike      <= 1'b0;
          refrac_cnt <= refrac_cnt - CW'(1);
          if (refrac_cnt == CW'(1)) state <= ST_INTEGRATE;
        end
      endcase
    end else begin
      spike <= 1'b0;
    end
  end

  assign refractory = (refrac_cnt != '0);
  assign fsm_state  = state;

endmodule

// File: tb/tb_lif_neuron_core.sv
// Bench for lif_neuron_core: two instances (default refractory and zero refractory) share
// stimulus; a reference model feeds an expected queue drained by a per-cycle monitor.
module tb_lif_neuron_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] current_in = '0;
  logic       in_valid = 1'b0;
  logic       thr_load = 1'b0;
  logic [7:0] thr_in = '0;

  logic [7:0] mem_a, cnt_a, mem_b, cnt_b;
  logic       spk_a, ref_a, st_a, spk_b, ref_b, st_b;

  int n_cmp = 0;
  int n_err = 0;

  logic [35:0] exp_q[$];

  // Reference model state, index 0 = refractory 4, index 1 = refractory 0
  int m_mem[2], m_ref[2], m_cnt[2], m_spk[2];
  int m_thr;
  int rc[2] = '{4, 0};

  lif_neuron_core u_dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena), .current_in(current_in), .in_valid(in_valid),
    .thr_load(thr_load), .thr_in(thr_in), .membrane(mem_a), .spike(spk_a),
    .refractory(ref_a), .spike_count(cnt_a), .fsm_state(st_a)
  );

  lif_neuron_core #(.REFRAC_CYCLES(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena), .current_in(current_in), .in_valid(in_valid),
    .thr_load(thr_load), .thr_in(thr_in), .membrane(mem_b), .spike(spk_b),
    .refractory(ref_b), .spike_count(cnt_b), .fsm_state(st_b)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_mem[d] = 0; m_ref[d] = 0; m_cnt[d] = 0; m_spk[d] = 0;
    end
    m_thr = 200;
  endtask

  function automatic logic [17:0] pack(int d);
    logic [7:0] mv, cv;
    mv = 8'(m_mem[d]);
    cv = 8'(m_cnt[d]);
    return {mv, (m_spk[d] != 0), (m_ref[d] > 0), cv};
  endfunction

  task automatic model_step(input logic e, input logic v, input int cur, input logic tl, input int ti);
    int leaked, sum;
    for (int d = 0; d < 2; d++) begin
      if (!e) begin
        m_spk[d] = 0;
      end else if (m_ref[d] > 0) begin
        m_ref[d] = m_ref[d] - 1;
        m_mem[d] = 0;
        m_spk[d] = 0;
      end else begin
        leaked = m_mem[d] - m_mem[d] / 16;
        sum = leaked + (v ? cur : 0);
        if (sum >= m_thr) begin
          m_mem[d] = 0;
          m_spk[d] = 1;
          m_cnt[d] = (m_cnt[d] + 1) % 256;
          m_ref[d] = rc[d];
        end else begin
          m_mem[d] = (sum > 255) ? 255 : sum;
          m_spk[d] = 0;
        end
      end
    end
    if (e && tl) m_thr = ti;
  endtask

  // Driver: one clock of stimulus, expected response queued for the monitor
  task automatic step(input logic e, input logic v, input int cur, input logic tl, input int ti);
    @(negedge clk);
    ena = e; in_valid = v; current_in = 8'(cur); thr_load = tl; thr_in = 8'(ti);
    model_step(e, v, cur, tl, ti);
    exp_q.push_back({pack(0), pack(1)});
  endtask

  task automatic settle();
    @(posedge clk);
    #3;
  endtask

  task automatic chk(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp_v);
    end
  endtask

  // Asynchronous reset applied between clock edges
  task automatic do_reset(input bit check_now);
    @(negedge clk);
    ena = 1'b0; in_valid = 1'b0; thr_load = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    if (check_now) begin
      chk("async_rst membrane", int'(mem_a), 0);
      chk("async_rst spike", int'(spk_a), 0);
      chk("async_rst refractory", int'(ref_a), 0);
      chk("async_rst count", int'(cnt_a), 0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor / scoreboard
  initial begin
    logic [35:0] e;
    logic [17:0] act_a, act_b;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act_a = {mem_a, spk_a, ref_a, cnt_a};
        act_b = {mem_b, spk_b, ref_b, cnt_b};
        n_cmp += 2;
        if (act_a !== e[35:18]) begin
          n_err++;
          $display("FAIL sb_refrac4 t=%0t: got mem=%0d spk=%0b ref=%0b cnt=%0d, want mem=%0d spk=%0b ref=%0b cnt=%0d",
                   $time, act_a[17:10], act_a[9], act_a[8], act_a[7:0],
                   e[35:28], e[27], e[26], e[25:18]);
        end
        if (act_b !== e[17:0]) begin
          n_err++;
          $display("FAIL sb_refrac0 t=%0t: got mem=%0d spk=%0b ref=%0b cnt=%0d, want mem=%0d spk=%0b ref=%0b cnt=%0d",
                   $time, act_b[17:10], act_b[9], act_b[8], act_b[7:0],
                   e[17:10], e[9], e[8], e[7:0]);
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    chk("reset membrane", int'(mem_a), 0);
    chk("reset spike", int'(spk_a), 0);
    chk("reset refractory", int'(ref_a), 0);
    chk("reset count", int'(cnt_a), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Constant current 100: 100, 194, then fire on 282
    step(1, 1, 100, 0, 0); settle(); chk("const mem1", int'(mem_a), 100);
    step(1, 1, 100, 0, 0); settle(); chk("const mem2", int'(mem_a), 194);
    step(1, 1, 100, 0, 0); settle();
    chk("const spike", int'(spk_a), 1);
    chk("const count", int'(cnt_a), 1);
    chk("const mem0", int'(mem_a), 0);
    chk("const refr", int'(ref_a), 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 100, 0, 0); settle();
      chk("refr held", int'(ref_a), 1);
      chk("refr no spike", int'(spk_a), 0);
    end
    step(1, 1, 100, 0, 0); settle(); chk("refr end", int'(ref_a), 0);
    step(1, 1, 100, 0, 0); settle(); chk("resume mem", int'(mem_a), 100);

    // Leak only
    do_reset(0);
    step(1, 1, 150, 0, 0); settle(); chk("leak 150", int'(mem_a), 150);
    step(1, 0, 0, 0, 0);   settle(); chk("leak 141", int'(mem_a), 141);
    step(1, 0, 0, 0, 0);   settle(); chk("leak 133", int'(mem_a), 133);
    step(1, 0, 0, 0, 0);   settle(); chk("leak 125", int'(mem_a), 125);
    chk("leak no spike", int'(spk_a), 0);

    // Threshold load: same-cycle compare uses old value
    do_reset(0);
    step(1, 1, 60, 1, 50); settle(); chk("thr same-cycle spike", int'(spk_a), 0);
    step(1, 1, 60, 0, 0);  settle(); chk("thr new spike", int'(spk_a), 1);

    // Threshold 0, zero current: the no-refractory instance fires every cycle
    do_reset(0);
    step(1, 0, 0, 1, 0);
    for (int i = 1; i <= 256; i++) begin
      step(1, 0, 0, 0, 0);
      if (i == 255) begin settle(); chk("thr0 count 255", int'(cnt_b), 255); end
    end
    settle();
    chk("thr0 count wrap", int'(cnt_b), 0);
    chk("thr0 spike", int'(spk_b), 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 200, 1, 100); settle();
      chk("ena0 spike", int'(spk_b), 0);
      chk("ena0 count", int'(cnt_b), 0);
    end
    step(1, 0, 0, 0, 0); settle(); chk("ena1 resume spike", int'(spk_b), 1);

    // Reset during refractory
    do_reset(0);
    for (int i = 0; i < 5; i++) step(1, 1, 100, 0, 0);
    settle();
    chk("pre-reset refr", int'(ref_a), 1);
    do_reset(1);
    step(1, 1, 100, 0, 0); settle(); chk("post-reset mem", int'(mem_a), 100);
    step(1, 1, 100, 0, 0);
    step(1, 1, 100, 0, 0); settle(); chk("post-reset thr200 spike", int'(spk_a), 1);

    // Randomized phase
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 9) < 7), int'($urandom_range(0, 255)),
           ($urandom_range(0, 19) == 0), int'($urandom_range(0, 255)));
    end

    for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(posedge clk);
    #4;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
